// File: rtl/multicycle_bus_adapter_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_bus_adapter_pkg
// Shared constants for the memory side of the multicycle core: the funct3
// width codes used by both the load/store datapath and the bus adapter, the
// adapter FSM state encoding, and a helper that recognises legal width codes.
// ---------------------------------------------------------------------------
package multicycle_bus_adapter_pkg;

    // Load width codes (funct3)
    localparam logic [2:0] FMT_LB  = 3'b000;
    localparam logic [2:0] FMT_LH  = 3'b001;
    localparam logic [2:0] FMT_LW  = 3'b010;
    localparam logic [2:0] FMT_LBU = 3'b100;
    localparam logic [2:0] FMT_LHU = 3'b101;

    // Store width codes share the encoding of the signed loads
    localparam logic [2:0] FMT_SB  = FMT_LB;
    localparam logic [2:0] FMT_SH  = FMT_LH;
    localparam logic [2:0] FMT_SW  = FMT_LW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    // True for the five width codes any load may use
    function automatic logic format_is_valid(input logic [2:0] format);
        return (format == FMT_LB)  || (format == FMT_LH) || (format == FMT_LW) ||
               (format == FMT_LBU) || (format == FMT_LHU);
    endfunction

endpackage

// File: rtl/multicycle_bus_adapter_bus_data_align.sv
// ---------------------------------------------------------------------------
// bus_data_align
// Purely combinational lane steering between the core and a word-wide bus.
// Ports:
//   format       in  3   funct3 width code
//   addr_low     in  2   byte offset within the word
//   wdata        in  32  low-aligned store data
//   rdata        in  32  word read from the bus
//   byte_enable  out 4   active byte lanes for the access
//   wdata_lanes  out 32  store data replicated across all lanes
//   rdata_ext    out 32  selected load data, sign/zero extended
//   misalign     out 1   halfword/word access not naturally aligned
// ---------------------------------------------------------------------------
module bus_data_align
    import multicycle_bus_adapter_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [1:0]  addr_low,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;

    // The addressed byte/halfword is moved down to bit 0 before extension
    assign shifted = rdata >> {addr_low, 3'b000};

    always_comb begin
        byte_enable = 4'b0000;
        wdata_lanes = 32'd0;
        rdata_ext   = 32'd0;
        misalign    = 1'b0;
        case (format)
            FMT_LB: begin
                byte_enable = 4'b0001 << addr_low;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{shifted[7]}}, shifted[7:0]};
            end
            FMT_LBU: begin
                byte_enable = 4'b0001 << addr_low;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {24'd0, shifted[7:0]};
            end
            FMT_LH: begin
                byte_enable = 4'b0011 << {addr_low[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{shifted[15]}}, shifted[15:0]};
                misalign    = addr_low[0];
            end
            FMT_LHU: begin
                byte_enable = 4'b0011 << {addr_low[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {16'd0, shifted[15:0]};
                misalign    = addr_low[0];
            end
            FMT_LW: begin
                byte_enable = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = shifted;
                misalign    = (addr_low != 2'b00);
            end
            default: begin
                byte_enable = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_bus_adapter.sv
// ---------------------------------------------------------------------------
// multicycle_bus_adapter
// Converts the core's held memory enables into one req/ack transaction on a
// word-wide bus with arbitrary wait states, and reports completion with a
// single-cycle core_done pulse (plus core_error on illegal access/timeout).
// Ports:
//   clock, reset          single clock, synchronous active-low reset
//   core_read_enable      load request, held until core_done
//   core_write_enable     store request, held until core_done
//   core_addr[31:0]       byte address
//   core_wdata[31:0]      low-aligned store data
//   core_format[2:0]      funct3 width code
//   core_rdata[31:0]      extended load result, held until next load
//   core_done, core_error completion pulse and its error qualifier
//   bus_req, bus_we       request valid and direction
//   bus_addr[31:0]        word address
//   bus_byte_enable[3:0]  active lanes
//   bus_wdata[31:0]       lane-replicated store data
//   bus_ack, bus_rdata    transfer complete and read word
// TIMEOUT_CYCLES: REQ cycles without ack before aborting (0 = never).
// ---------------------------------------------------------------------------
module multicycle_bus_adapter
    import multicycle_bus_adapter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_format,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    bus_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  format_q;
    logic        write_q;
    logic        error_q;
    logic [31:0] timeout_count;

    logic        idle;
    logic [2:0]  align_format;
    logic [1:0]  align_addr_low;
    logic [31:0] align_wdata;
    logic [3:0]  align_byte_enable;
    logic [31:0] align_wdata_lanes;
    logic [31:0] align_rdata_ext;
    logic        align_misalign;
    logic        access_legal;
    logic        timeout_hit;

    // In IDLE the aligner looks at the live core request so legality can be
    // decided in the same cycle; afterwards it only sees latched values, which
    // keeps every bus output stable and free of core-side combinational paths.
    assign idle           = (state == ST_IDLE);
    assign align_format   = idle ? core_format     : format_q;
    assign align_addr_low = idle ? core_addr[1:0]  : addr_q[1:0];
    assign align_wdata    = idle ? core_wdata      : wdata_q;

    bus_data_align u_align (
        .format      (align_format),
        .addr_low    (align_addr_low),
        .wdata       (align_wdata),
        .rdata       (bus_rdata),
        .byte_enable (align_byte_enable),
        .wdata_lanes (align_wdata_lanes),
        .rdata_ext   (align_rdata_ext),
        .misalign    (align_misalign)
    );

    // Stores have no unsigned variants, so formats with bit 2 set are loads only
    assign access_legal = format_is_valid(core_format) && !align_misalign &&
                          !(core_read_enable && core_write_enable) &&
                          !(core_write_enable && core_format[2]);

    // Counter holds the number of ack-less REQ cycles already completed
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((timeout_count + 32'd1) == TIMEOUT_LIMIT);

    // Bus and completion outputs are decoded from state and latched fields only
    assign bus_req         = (state == ST_REQ);
    assign bus_we          = bus_req & write_q;
    assign bus_addr        = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_byte_enable = bus_req ? align_byte_enable : 4'b0000;
    assign bus_wdata       = (bus_req & write_q) ? align_wdata_lanes : 32'd0;
    assign core_done       = (state == ST_DONE);
    assign core_error      = core_done & error_q;

    // Transaction FSM with latched request fields, timeout counter and the
    // load result register; an ack wins over a timeout in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            format_q      <= 3'd0;
            write_q       <= 1'b0;
            error_q       <= 1'b0;
            timeout_count <= 32'd0;
            core_rdata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core_read_enable || core_write_enable) begin
                        addr_q        <= core_addr;
                        wdata_q       <= core_wdata;
                        format_q      <= core_format;
                        write_q       <= core_write_enable;
                        timeout_count <= 32'd0;
                        if (access_legal) begin
                            error_q <= 1'b0;
                            state   <= ST_REQ;
                        end else begin
                            error_q <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        if (!write_q) begin
                            core_rdata <= align_rdata_ext;
                        end
                        error_q <= 1'b0;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        timeout_count <= timeout_count + 32'd1;
                    end
                end
                ST_DONE: begin
                    error_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_bus_adapter.sv
// ---------------------------------------------------------------------------
// tb_multicycle_bus_adapter
// Self-checking bench: directed accesses followed by random ones, each
// compared cycle by cycle against expectations derived from access rules.
// ---------------------------------------------------------------------------
module tb_multicycle_bus_adapter;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        core_read_enable = 1'b0;
    logic        core_write_enable = 1'b0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wdata = 32'd0;
    logic [2:0]  core_format = 3'd0;
    logic [31:0] core_rdata;
    logic        core_done;
    logic        core_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'd0;

    multicycle_bus_adapter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock             (clock),
        .reset             (reset),
        .core_read_enable  (core_read_enable),
        .core_write_enable (core_write_enable),
        .core_addr         (core_addr),
        .core_wdata        (core_wdata),
        .core_format       (core_format),
        .core_rdata        (core_rdata),
        .core_done         (core_done),
        .core_error        (core_error),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_byte_enable   (bus_byte_enable),
        .bus_wdata         (bus_wdata),
        .bus_ack           (bus_ack),
        .bus_rdata         (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Everything quiet: used after reset and in idle cycles
    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".req"},   32'(bus_req), 32'd0);
        checkOutput({tag, ".done"},  32'(core_done), 32'd0);
        checkOutput({tag, ".err"},   32'(core_error), 32'd0);
        checkOutput({tag, ".rdata"}, core_rdata, model_rdata);
    endtask

    // One complete access. waits = REQ cycles before ack, -1 = never ack.
    task automatic applyStimulus(input logic re, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [2:0] fmt, input int waits,
                                 input logic [31:0] rd, input logic late_ack);
        int          size;
        int          off;
        int          be_int;
        int          req_cycles;
        logic        legal;
        logic        ack_now;
        logic [63:0] mask;
        logic [63:0] v;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ext;

        // Expected behaviour from the access rules
        case (fmt)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        off   = int'(addr[1:0]);
        legal = (size != 0) && !(re && we) && ((off % ((size == 0) ? 1 : size)) == 0) &&
                !(we && fmt[2]);
        be_int = (((1 << size) - 1) << off) & 15;
        if (size == 1)      exp_wdata = {24'd0, wd[7:0]} * 32'h01010101;
        else if (size == 2) exp_wdata = {16'd0, wd[15:0]} * 32'h00010001;
        else                exp_wdata = wd;
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = ({32'd0, rd} >> (8 * off)) & mask;
        if (size != 0 && size < 4 && !fmt[2] && v[8 * size - 1]) v = v | ~mask;
        exp_ext = v[31:0];

        @(posedge clock); #1;
        core_read_enable  = re;
        core_write_enable = we;
        core_addr         = addr;
        core_wdata        = wd;
        core_format       = fmt;
        bus_ack           = 1'b0;
        @(posedge clock); #1;

        if (!legal) begin
            core_read_enable  = 1'b0;
            core_write_enable = 1'b0;
            @(negedge clock);
            checkOutput("illegal.done",  32'(core_done), 32'd1);
            checkOutput("illegal.err",   32'(core_error), 32'd1);
            checkOutput("illegal.req",   32'(bus_req), 32'd0);
            checkOutput("illegal.rdata", core_rdata, model_rdata);
        end else begin
            req_cycles = (waits < 0) ? TIMEOUT : waits + 1;
            for (int c = 0; c < req_cycles; c++) begin
                ack_now   = (waits >= 0) && (c == waits);
                bus_ack   = ack_now;
                bus_rdata = ack_now ? rd : $urandom;
                @(negedge clock);
                checkOutput("req.req",  32'(bus_req), 32'd1);
                checkOutput("req.we",   32'(bus_we), 32'(we));
                checkOutput("req.addr", bus_addr, {addr[31:2], 2'b00});
                checkOutput("req.be",   32'(bus_byte_enable), 32'(be_int));
                if (we) checkOutput("req.wdata", bus_wdata, exp_wdata);
                checkOutput("req.done", 32'(core_done), 32'd0);
                @(posedge clock); #1;
            end
            bus_ack = 1'b0;
            if (waits >= 0 && re) model_rdata = exp_ext;
            if (late_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = $urandom;
            end
            core_read_enable  = 1'b0;
            core_write_enable = 1'b0;
            @(negedge clock);
            checkOutput("done.done",  32'(core_done), 32'd1);
            checkOutput("done.err",   32'(core_error), 32'(waits < 0));
            checkOutput("done.req",   32'(bus_req), 32'd0);
            checkOutput("done.rdata", core_rdata, model_rdata);
        end
        @(posedge clock); #1;
        bus_ack = 1'b0;
        @(negedge clock);
        checkQuiet("after");
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkQuiet("reset");
        checkOutput("reset.addr", bus_addr, 32'd0);
        checkOutput("reset.be",   32'(bus_byte_enable), 32'd0);
        checkOutput("reset.wd",   bus_wdata, 32'd0);
        checkOutput("reset.we",   32'(bus_we), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Directed accesses
        applyStimulus(1'b0, 1'b1, 32'h103, 32'hAB, 3'b000, 0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'd0, 3'b000, 3, 32'h00F00000, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'd0, 3'b100, 3, 32'h00F00000, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h6, 32'd0, 3'b010, 0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 3'b010, -1, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'd0, 3'b010, 0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h1234, 3'b100, 0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 3'b011, 0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h43, 32'd0, 3'b001, 0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h42, 32'd0, 3'b001, 1, 32'h8001_7FFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h42, 32'hCAFE_BEEF, 3'b001, 2, 32'd0, 1'b0);

        // Reset in the middle of an SW request
        @(posedge clock); #1;
        core_write_enable = 1'b1;
        core_addr         = 32'h20;
        core_wdata        = 32'h5555_AAAA;
        core_format       = 3'b010;
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("midrst.req", 32'(bus_req), 32'd1);
        reset             = 1'b0;
        core_write_enable = 1'b0;
        @(posedge clock); #1;
        model_rdata = 32'd0;
        @(negedge clock);
        checkQuiet("midrst");
        checkOutput("midrst.addr", bus_addr, 32'd0);
        checkOutput("midrst.be",   32'(bus_byte_enable), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checkQuiet("midrst2");
        applyStimulus(1'b1, 1'b0, 32'h24, 32'd0, 3'b010, 1, 32'h1357_9BDF, 1'b0);

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            int          sel;
            int          w;
            logic        re;
            logic        we;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            re  = (sel == 0) || (sel < 5);
            we  = (sel == 0) || (sel >= 5);
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            w   = $urandom_range(0, 8);
            if (w > 3) w = (w == 8) ? -1 : w - 4;
            applyStimulus(re, we, a, $urandom, 3'($urandom_range(0, 7)), w,
                          $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
